complex_result_serializer: RTL and testbench

Downstream stage of `complex_matrix_add`. It captures one full result vector of SIZE complex elements in a single handshake (`result_o` of the adder, 2*SIZE words of WIDTH bits). It then streams the vector out one complex element per beat, each beat carrying an index and a last flag, under valid/ready backpressure. This decouples the wide parallel adder output from narrow consumers such as the writeback/store path.

---
 rtl/complex_result_serializer_if.sv | 30 +++
 rtl/complex_result_serializer.sv | 141 ++++++++++++++
 tb/tb_complex_result_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_result_serializer_if.sv
// Bus between a result-vector producer/consumer pair and complex_result_serializer.
// The producer side drives the vector and flush; the consumer side drives out_ready_i.
interface complex_result_serializer_if #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
);
  localparam int IDXW = $clog2(SIZE);

  logic                            in_valid_i;
  logic                            in_ready_o;
  logic                            flush_i;
  logic [2*SIZE-1:0][WIDTH-1:0]    result_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [WIDTH-1:0]                out_re_o;
  logic [WIDTH-1:0]                out_im_o;
  logic [IDXW-1:0]                 out_idx_o;
  logic                            out_last_o;
  logic                            busy_o;

  modport slave (
    input  in_valid_i, flush_i, result_i, out_ready_i,
    output in_ready_o, out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o, busy_o
  );

  modport master (
    output in_valid_i, flush_i, result_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_re_o, out_im_o, out_idx_o, out_last_o, busy_o
  );
endinterface

// File: rtl/complex_result_serializer.sv
// Captures a full complex result vector in one handshake and streams it one element per beat.
// Optional pending buffer for bubble-free back-to-back vectors: define CRS_DOUBLE_BUF_EN.
module complex_result_serializer #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  complex_result_serializer_if.slave bus
);
  localparam int IDXW = $clog2(SIZE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SIZE - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                       state_reg, state_next;
  logic [IDXW-1:0]              idx_reg, idx_next;
  logic [2*SIZE-1:0][WIDTH-1:0] act_reg;
  logic                         load_act;
  logic                         pend_valid;
  logic                         out_valid;
  logic                         accept;
  logic                         out_hs;
  logic                         at_last;

`ifdef CRS_DOUBLE_BUF_EN
  logic [2*SIZE-1:0][WIDTH-1:0] pend_reg;
  logic                         pend_valid_reg, pend_valid_next;
  logic                         load_pend;
  logic                         promote;

  assign pend_valid     = pend_valid_reg;
  assign bus.in_ready_o = !pend_valid_reg;
`else
  assign pend_valid     = 1'b0;
  assign bus.in_ready_o = (state_reg == IDLE);
`endif

  assign out_valid = (state_reg == STREAM);
  assign accept    = bus.in_valid_i && bus.in_ready_o;
  assign out_hs    = out_valid && bus.out_ready_i;
  assign at_last   = (idx_reg == LAST_IDX);

  // Flush wins over both handshakes; the offered vector and the current beat are dropped.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_act   = 1'b0;
`ifdef CRS_DOUBLE_BUF_EN
    load_pend       = 1'b0;
    promote         = 1'b0;
    pend_valid_next = pend_valid_reg;
`endif
    if (bus.flush_i) begin
      state_next = IDLE;
      idx_next   = '0;
`ifdef CRS_DOUBLE_BUF_EN
      pend_valid_next = 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            load_act   = 1'b1;
            idx_next   = '0;
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (out_hs && at_last) begin
            idx_next = '0;
`ifdef CRS_DOUBLE_BUF_EN
            if (pend_valid_reg) begin
              promote         = 1'b1;
              pend_valid_next = 1'b0;
            end else if (accept) begin
              load_act = 1'b1;
            end else begin
              state_next = IDLE;
            end
`else
            state_next = IDLE;
`endif
          end else begin
            if (out_hs) begin
              idx_next = idx_reg + 1'b1;
            end
`ifdef CRS_DOUBLE_BUF_EN
            if (accept) begin
              load_pend       = 1'b1;
              pend_valid_next = 1'b1;
            end
`endif
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
`ifdef CRS_DOUBLE_BUF_EN
      pend_valid_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
`ifdef CRS_DOUBLE_BUF_EN
      pend_valid_reg <= pend_valid_next;
`endif
    end
  end

  // Data buffers need no reset: outputs are gated by out_valid.
  always_ff @(posedge clk_i) begin
    if (load_act) begin
      act_reg <= bus.result_i;
    end
`ifdef CRS_DOUBLE_BUF_EN
    else if (promote) begin
      act_reg <= pend_reg;
    end
    if (load_pend) begin
      pend_reg <= bus.result_i;
    end
`endif
  end

  assign bus.out_valid_o = out_valid;
  assign bus.out_re_o    = out_valid ? act_reg[{idx_reg, 1'b0}] : '0;
  assign bus.out_im_o    = out_valid ? act_reg[{idx_reg, 1'b1}] : '0;
  assign bus.out_idx_o   = out_valid ? idx_reg : '0;
  assign bus.out_last_o  = out_valid && at_last;
  assign bus.busy_o      = out_valid || pend_valid;
endmodule

// File: tb/tb_complex_result_serializer.sv
// Directed self-checking bench for complex_result_serializer (either buffer build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_complex_result_serializer;
  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int IDXW  = 4;
  typedef logic [2*SIZE-1:0][WIDTH-1:0] vec_t;

`ifdef CRS_DOUBLE_BUF_EN
  localparam int EXP_B_T    = 1;
  localparam int EXP_LAST_T = 32;
`else
  localparam int EXP_B_T    = 17;
  localparam int EXP_LAST_T = 33;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  vec_t vec_a, vec_b;

  always #5 clk = ~clk;

  complex_result_serializer_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

  complex_result_serializer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic vec_t make_vec(input logic [63:0] re_base, input logic [63:0] im_base);
    vec_t v;
    for (int i = 0; i < SIZE; i++) begin
      v[2*i]   = re_base + 64'(i);
      v[2*i+1] = im_base + 64'(i);
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid_i  = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.result_i    = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_last_o, bus.out_idx_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}
        || bus.out_re_o !== 64'd0 || bus.out_im_o !== 64'd0)
      begin failures++; $display("FAIL reset_state rdy=%0b vld=%0b busy=%0b last=%0b idx=%0d re=%h im=%h required rdy=1 others 0",
        bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_last_o, bus.out_idx_o, bus.out_re_o, bus.out_im_o); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_single();
    logic [63:0] exp_re, exp_im;
    logic        exp_last;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.result_i    = vec_a;
    bus.in_valid_i  = 1'b1;
    checks++;
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%0b required=1", bus.in_ready_o); end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.result_i   = '0;
    for (int i = 0; i < SIZE; i++) begin
      exp_re   = 64'h4018000000000000 + 64'(i);
      exp_im   = 64'(i);
      exp_last = (i == SIZE - 1);
      checks++;
      if ({bus.out_valid_o, bus.busy_o, bus.out_idx_o, bus.out_last_o} !== {1'b1, 1'b1, IDXW'(i), exp_last}
          || bus.out_re_o !== exp_re || bus.out_im_o !== exp_im)
        begin failures++; $display("FAIL single_beat%0d vld=%0b busy=%0b idx=%0d last=%0b re=%h im=%h required idx=%0d last=%0b re=%h im=%h",
          i, bus.out_valid_o, bus.busy_o, bus.out_idx_o, bus.out_last_o, bus.out_re_o, bus.out_im_o, i, exp_last, exp_re, exp_im); end
      $display("single beat idx=%0d re=%h im=%h last=%0b", bus.out_idx_o, bus.out_re_o, bus.out_im_o, bus.out_last_o);
      @(negedge clk);
    end
    checks++;
    if ({bus.out_valid_o, bus.busy_o, bus.in_ready_o} !== 3'b001 || bus.out_re_o !== 64'd0)
      begin failures++; $display("FAIL single_done vld=%0b busy=%0b rdy=%0b re=%h required vld=0 busy=0 rdy=1 re=0",
        bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.out_re_o); end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int   e = 0;
    int   t = 0;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.result_i    = vec_b;
    bus.in_valid_i  = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    while (e < SIZE && t < 200) begin
      checks++;
      if ({bus.out_valid_o, bus.out_idx_o} !== {1'b1, IDXW'(e)}
          || bus.out_re_o !== 64'hC008000000000000 + 64'(e) || bus.out_im_o !== 64'h100 + 64'(e))
        begin failures++; $display("FAIL bp_beat t=%0d vld=%0b idx=%0d re=%h im=%h required idx=%0d re=%h im=%h",
          t, bus.out_valid_o, bus.out_idx_o, bus.out_re_o, bus.out_im_o, e, 64'hC008000000000000 + 64'(e), 64'h100 + 64'(e)); end
      bus.out_ready_i = pat[t % 4];
      $display("bp cycle t=%0d idx=%0d ready=%0b", t, bus.out_idx_o, bus.out_ready_i);
      if (bus.out_ready_i) e++;
      t++;
      @(negedge clk);
    end
    checks++;
    if (e != SIZE || bus.out_valid_o !== 1'b0)
      begin failures++; $display("FAIL bp_done delivered=%0d vld=%0b required delivered=%0d vld=0", e, bus.out_valid_o, SIZE); end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int stage  = 0;
    int p      = 0;
    int b_t    = -1;
    int first_t = -1;
    int last_t = -1;
    logic [63:0] exp_re, exp_im;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    for (int t = 0; t < 45; t++) begin
      if (bus.out_valid_o) begin
        if (p < SIZE) begin
          exp_re = 64'h4018000000000000 + 64'(p);
          exp_im = 64'(p);
        end else begin
          exp_re = 64'hC008000000000000 + 64'(p - SIZE);
          exp_im = 64'h100 + 64'(p - SIZE);
        end
        checks++;
        if (p >= 2*SIZE || bus.out_idx_o !== IDXW'(p % SIZE) || bus.out_re_o !== exp_re || bus.out_im_o !== exp_im
            || bus.out_last_o !== ((p % SIZE) == SIZE - 1))
          begin failures++; $display("FAIL b2b_beat%0d t=%0d idx=%0d re=%h im=%h last=%0b required idx=%0d re=%h im=%h",
            p, t, bus.out_idx_o, bus.out_re_o, bus.out_im_o, bus.out_last_o, p % SIZE, exp_re, exp_im); end
        $display("b2b beat t=%0d idx=%0d re=%h", t, bus.out_idx_o, bus.out_re_o);
        if (first_t < 0) first_t = t;
        last_t = t;
        p++;
      end
      if (stage >= 2) begin
        bus.in_valid_i = 1'b0;
      end else begin
        bus.in_valid_i = 1'b1;
        bus.result_i   = (stage == 0) ? vec_a : vec_b;
        if (bus.in_ready_o) begin
          if (stage == 1) b_t = t;
          stage++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (p != 2*SIZE) begin failures++; $display("FAIL b2b_count got=%0d required=%0d", p, 2*SIZE); end
    checks++;
    if (b_t != EXP_B_T) begin failures++; $display("FAIL b2b_second_accept got=%0d required=%0d", b_t, EXP_B_T); end
    checks++;
    if (first_t != 1 || last_t != EXP_LAST_T)
      begin failures++; $display("FAIL b2b_timing first=%0d last=%0d required first=1 last=%0d", first_t, last_t, EXP_LAST_T); end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    int t = 0;
    int seen = 0;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.result_i    = vec_a;
    bus.in_valid_i  = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    while (!(bus.out_valid_o && bus.out_idx_o == 4'd5) && t < 30) begin
      t++;
      @(negedge clk);
    end
    checks++;
    if (bus.out_idx_o !== 4'd5 || bus.out_re_o !== 64'h4018000000000005)
      begin failures++; $display("FAIL flush_reach_idx5 idx=%0d re=%h required idx=5 re=4018000000000005", bus.out_idx_o, bus.out_re_o); end
    bus.flush_i    = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.result_i   = vec_b;
    @(negedge clk);
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    checks++;
    if ({bus.out_valid_o, bus.busy_o, bus.in_ready_o} !== 3'b001 || bus.out_re_o !== 64'd0)
      begin failures++; $display("FAIL flush_after vld=%0b busy=%0b rdy=%0b re=%h required vld=0 busy=0 rdy=1 re=0",
        bus.out_valid_o, bus.busy_o, bus.in_ready_o, bus.out_re_o); end
    $display("flush applied at idx=5");
    repeat (20) begin
      if (bus.out_valid_o) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_emit valid_cycles=%0d required=0", seen); end
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_rst_mid();
    int seen = 0;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.result_i    = vec_b;
    bus.in_valid_i  = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'd3)
      begin failures++; $display("FAIL rst_mid_pre vld=%0b idx=%0d required vld=1 idx=3", bus.out_valid_o, bus.out_idx_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_last_o, bus.out_idx_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}
        || bus.out_re_o !== 64'd0 || bus.out_im_o !== 64'd0)
      begin failures++; $display("FAIL rst_mid_state rdy=%0b vld=%0b busy=%0b last=%0b idx=%0d re=%h im=%h required rdy=1 others 0",
        bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_last_o, bus.out_idx_o, bus.out_re_o, bus.out_im_o); end
    $display("mid-stream reset applied");
    repeat (5) begin
      if (bus.out_valid_o) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rst_mid_resume valid_cycles=%0d required=0", seen); end
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    vec_a = make_vec(64'h4018000000000000, 64'h0);
    vec_b = make_vec(64'hC008000000000000, 64'h100);
    idle_inputs();
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required finish before 200000", $time);
    $fatal(1, "timeout");
  end
endmodule
